// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA timing: pixel-rate divider, H/V region FSMs, scaled VRAM address
// generation and a one-pixel output pipeline that aligns sync/blanking with rgb_in.
module vga_timing_generator #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SCALE     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rgb_in,
    output logic [13:0] read_address,
    output logic [3:0]  front_porch_count,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  vga_rgb
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_SAMP   = DW'(CLK_DIV - 2);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_FP_START = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SY_START = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] H_BP_START = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_FP_START = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SY_START = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] V_BP_START = VW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
    localparam logic [6:0]    COL_MAX    = 7'd127;
    localparam logic [6:0]    ROW_MAX    = 7'd95;

    typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNCP, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNCP, V_BACK} v_state_t;

    h_state_t       h_state, h_state_nxt;
    v_state_t       v_state, v_state_nxt;
    logic [DW-1:0]  div;
    logic [HW-1:0]  h_cnt, h_nxt;
    logic [VW-1:0]  v_cnt, v_nxt;
    logic [SW-1:0]  sub_x, sub_x_nxt, sub_y, sub_y_nxt;
    logic [6:0]     vram_col, col_nxt, vram_row, row_nxt;
    logic [2:0]     rgb_s;
    logic [3:0]     fp_nxt;
    logic           tick, line_end, frame_end, pix_active;

    always_comb begin
        tick       = (div == DIV_LAST);
        line_end   = (h_cnt == H_LAST);
        frame_end  = line_end && (v_cnt == V_LAST);
        h_nxt      = line_end ? '0 : h_cnt + 1'b1;
        v_nxt      = frame_end ? '0 : (line_end ? v_cnt + 1'b1 : v_cnt);
        pix_active = (h_state == H_ACTIVE) && (v_state == V_ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_state <= H_ACTIVE;
            v_state <= V_ACTIVE;
        end else if (tick) begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
        end
    end

    always_comb begin
        h_state_nxt = h_state;
        case (h_state)
            H_ACTIVE: if (h_nxt == H_FP_START) h_state_nxt = H_FRONT;
            H_FRONT:  if (h_nxt == H_SY_START) h_state_nxt = H_SYNCP;
            H_SYNCP:  if (h_nxt == H_BP_START) h_state_nxt = H_BACK;
            H_BACK:   if (line_end)            h_state_nxt = H_ACTIVE;
            default:                           h_state_nxt = H_ACTIVE;
        endcase
        v_state_nxt = v_state;
        case (v_state)
            V_ACTIVE: if (line_end && v_nxt == V_FP_START) v_state_nxt = V_FRONT;
            V_FRONT:  if (line_end && v_nxt == V_SY_START) v_state_nxt = V_SYNCP;
            V_SYNCP:  if (line_end && v_nxt == V_BP_START) v_state_nxt = V_BACK;
            V_BACK:   if (frame_end)                       v_state_nxt = V_ACTIVE;
            default:                                       v_state_nxt = V_ACTIVE;
        endcase
    end

    // Scaled address counters; col/row saturate so they never spill into the next row.
    always_comb begin
        sub_x_nxt = sub_x;
        col_nxt   = vram_col;
        sub_y_nxt = sub_y;
        row_nxt   = vram_row;
        if (line_end) begin
            sub_x_nxt = '0;
            col_nxt   = '0;
        end else if (h_state == H_ACTIVE) begin
            if (sub_x == SUB_LAST) begin
                sub_x_nxt = '0;
                if (vram_col != COL_MAX) col_nxt = vram_col + 1'b1;
            end else begin
                sub_x_nxt = sub_x + 1'b1;
            end
        end
        if (frame_end) begin
            sub_y_nxt = '0;
            row_nxt   = '0;
        end else if (line_end && v_state == V_ACTIVE) begin
            if (sub_y == SUB_LAST) begin
                sub_y_nxt = '0;
                if (vram_row != ROW_MAX) row_nxt = vram_row + 1'b1;
            end else begin
                sub_y_nxt = sub_y + 1'b1;
            end
        end
        fp_nxt = front_porch_count;
        if (line_end) begin
            if (v_state_nxt == V_FRONT)
                fp_nxt = (v_state != V_FRONT) ? 4'd1 :
                         (front_porch_count == 4'hF) ? 4'hF : front_porch_count + 1'b1;
            else
                fp_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div               <= '0;
            h_cnt             <= '0;
            v_cnt             <= '0;
            sub_x             <= '0;
            sub_y             <= '0;
            vram_col          <= '0;
            vram_row          <= '0;
            rgb_s             <= '0;
            read_address      <= '0;
            front_porch_count <= '0;
            frame_start       <= 1'b0;
            hsync             <= 1'b1;
            vsync             <= 1'b1;
            vga_rgb           <= '0;
        end else begin
            div         <= tick ? '0 : div + 1'b1;
            frame_start <= 1'b0;
            // Last clk before the tick: memory_management has had CLK_DIV-1 clks to respond.
            if (div == DIV_SAMP) rgb_s <= rgb_in;
            if (tick) begin
                h_cnt             <= h_nxt;
                v_cnt             <= v_nxt;
                sub_x             <= sub_x_nxt;
                sub_y             <= sub_y_nxt;
                vram_col          <= col_nxt;
                vram_row          <= row_nxt;
                front_porch_count <= fp_nxt;
                frame_start       <= line_end && (v_nxt == V_FP_START);
                read_address      <= (h_state_nxt == H_ACTIVE && v_state_nxt == V_ACTIVE)
                                     ? {row_nxt, col_nxt} : '0;
                // Pins take the state of the pixel just finished, one pixel behind counters.
                hsync             <= (h_state != H_SYNCP);
                vsync             <= (v_state != V_SYNCP);
                vga_rgb           <= pix_active ? rgb_s : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: a per-clk arithmetic model pushes expected outputs, a monitor pops and compares.
module tb_vga_timing_generator;
    localparam int CD = 3, HV = 260, HFP = 3, HS = 4, HB = 2;
    localparam int VV = 10, VFP = 4, VS = 2, VB = 3, SC = 2;
    localparam int HT = HV + HFP + HS + HB;
    localparam int VT = VV + VFP + VS + VB;
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLKS = FRAME_PIX * CD;

    typedef struct packed {
        logic [13:0] addr;
        logic [3:0]  fp;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [2:0]  rgb;
    } obs_t;

    logic        clk, reset;
    logic [2:0]  rgb_in;
    logic [13:0] read_address;
    logic [3:0]  front_porch_count;
    logic        frame_start, hsync, vsync;
    logic [2:0]  vga_rgb;

    int checks = 0, errors = 0;
    int cur_h = 0, cur_v = 0;
    bit const_mode = 0;
    obs_t exp_q[$];
    logic [2:0] samp[int];

    vga_timing_generator #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SCALE(SC)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .read_address(read_address),
        .front_porch_count(front_porch_count), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
            if (errors >= 40) finish_sim();
        end
    endtask

    function automatic bit is_act(int h, int v);
        return h < HV && v < VV;
    endfunction

    function automatic logic [13:0] addr_of(int h, int v);
        int c, r;
        if (!is_act(h, v)) return '0;
        c = h / SC; if (c > 127) c = 127;
        r = v / SC; if (r > 95) r = 95;
        return 14'(r * 128 + c);
    endfunction

    // Reference model: n = clk edges since reset release; pixel q = n / CD.
    initial begin
        int n, q, pix, h, v, pq, ph, pv;
        obs_t e;
        n = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                n = 0;
                samp.delete();
            end else begin
                if (n % CD == CD - 2) samp[n / CD] = rgb_in;
                n++;
            end
            q   = n / CD;
            pix = q % FRAME_PIX;
            h   = pix % HT;
            v   = pix / HT;
            cur_h = h;
            cur_v = v;
            e.addr = addr_of(h, v);
            e.fp   = (v >= VV && v < VV + VFP) ? 4'(v - VV + 1) : 4'd0;
            e.fs   = (!reset && n > 0 && n % CD == 0 && h == 0 && v == VV);
            if (reset || q == 0) begin
                e.hs = 1; e.vs = 1; e.rgb = 0;
            end else begin
                pq = (q - 1) % FRAME_PIX;
                ph = pq % HT;
                pv = pq / HT;
                e.hs  = !(ph >= HV + HFP && ph < HV + HFP + HS);
                e.vs  = !(pv >= VV + VFP && pv < VV + VFP + VS);
                e.rgb = is_act(ph, pv) ? samp[q - 1] : 3'd0;
            end
            exp_q.push_back(e);
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("read_address", 16'(read_address), 16'(e.addr));
                check("front_porch_count", 16'(front_porch_count), 16'(e.fp));
                check("frame_start", 16'(frame_start), 16'(e.fs));
                check("hsync", 16'(hsync), 16'(e.hs));
                check("vsync", 16'(vsync), 16'(e.vs));
                check("vga_rgb", 16'(vga_rgb), 16'(e.rgb));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rgb_in = const_mode ? 3'b101 : 3'($urandom_range(7, 0));
        end
    end

    initial begin
        bit found;
        reset  = 1;
        rgb_in = 0;
        repeat (3) @(negedge clk);
        #1 reset = 0;

        found = 0;
        for (int i = 0; i < FRAME_CLKS + 10 && !found; i++) begin
            @(negedge clk);
            found = frame_start;
        end
        check("frame_start_seen", 16'(found), 16'd1);

        const_mode = 1;
        repeat (FRAME_CLKS) @(negedge clk);
        const_mode = 0;

        found = 0;
        for (int i = 0; i < FRAME_CLKS + 10 && !found; i++) begin
            @(negedge clk);
            found = (cur_v == 7 && cur_h == 100);
        end
        check("reach_mid_frame", 16'(found), 16'd1);

        #1 reset = 1;
        #1;
        check("rst_read_address", 16'(read_address), 16'd0);
        check("rst_front_porch", 16'(front_porch_count), 16'd0);
        check("rst_frame_start", 16'(frame_start), 16'd0);
        check("rst_hsync", 16'(hsync), 16'd1);
        check("rst_vsync", 16'(vsync), 16'd1);
        check("rst_vga_rgb", 16'(vga_rgb), 16'd0);
        repeat (3) @(negedge clk);
        #1 reset = 0;

        repeat (FRAME_CLKS + FRAME_CLKS / 2) @(negedge clk);
        finish_sim();
    end
endmodule
